// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the CPU memory stage and a 32-bit word-ported data RAM.
// Decodes RV32I widths, extends loads, and does read-modify-write for SB/SH.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [31:0]       mem_a_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_MERGE,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [31:0]         mem_a_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_wd_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [15:0]         wdata_q;

  logic [2:0]          size_m1_d;
  logic [ADDR_W:0]     end_d;
  logic                f3_bad_d;
  logic                hi_bad_d;
  logic                req_err_d;

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [DATA_W-1:0] w);
    case (f3)
      3'd0:    load_ext = {{24{w[7]}}, w[7:0]};
      3'd1:    load_ext = {{16{w[15]}}, w[15:0]};
      3'd4:    load_ext = {24'd0, w[7:0]};
      3'd5:    load_ext = {16'd0, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] merge_word(input logic [2:0] f3,
                                                   input logic [DATA_W-1:0] old,
                                                   input logic [15:0] wd);
    if (f3[0]) merge_word = {old[31:16], wd};
    else       merge_word = {old[31:8], wd[7:0]};
  endfunction

  // Request decode: size, direction-specific funct3 legality, and range without wraparound.
  always_comb begin
    case (funct3_i[1:0])
      2'd0:    size_m1_d = 3'd0;
      2'd1:    size_m1_d = 3'd1;
      default: size_m1_d = 3'd3;
    endcase
    f3_bad_d  = req_we_i ? (funct3_i >= 3'd3)
                         : (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7);
    hi_bad_d  = |addr_i[31:ADDR_W];
    end_d     = {1'b0, addr_i[ADDR_W-1:0]} + (ADDR_W+1)'(size_m1_d);
    req_err_d = f3_bad_d | hi_bad_d | end_d[ADDR_W];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_wd_q    <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          if (req_valid_i) begin
            ready_q     <= 1'b0;
            we_q        <= req_we_i;
            f3_q        <= funct3_i;
            wdata_q     <= wdata_i[15:0];
            rsp_rdata_q <= '0;
            if (req_err_d) begin
              state_q     <= S_ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              // SW drives the write during ACCESS, so its enable and data are set up here.
              state_q  <= S_ACCESS;
              mem_a_q  <= addr_i;
              mem_we_q <= req_we_i && (funct3_i[1:0] == 2'd2);
              mem_wd_q <= wdata_i;
            end
          end
        end
        S_ACCESS: begin
          mem_we_q <= 1'b0;
          if (!we_q) begin
            rsp_rdata_q <= load_ext(f3_q, mem_rd_i);
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (f3_q[1:0] == 2'd2) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            mem_we_q <= 1'b1;
            mem_wd_q <= merge_word(f3_q, mem_rd_i, wdata_q);
            state_q  <= S_MERGE;
          end
        end
        S_MERGE: begin
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_a_o     = mem_a_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wd_o    = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with a byte-array RAM model that commits on the falling edge.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [7:0]  ram [0:131071];
  logic [16:0] ra0, ra1, ra2, ra3;
  int          we_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_wa, last_wd;
  int          cmp = 0;
  int          bad = 0;

  lsu_mem_ctrl #(.ADDR_W(17), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_a_o(mem_a), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  assign ra0 = mem_a[16:0];
  assign ra1 = ra0 + 17'd1;
  assign ra2 = ra0 + 17'd2;
  assign ra3 = ra0 + 17'd3;
  assign mem_rd = {ram[ra3], ram[ra2], ram[ra1], ram[ra0]};

  always @(negedge clk) begin
    if (mem_we) begin
      ram[ra0] = mem_wd[7:0];
      ram[ra1] = mem_wd[15:8];
      ram[ra2] = mem_wd[23:16];
      ram[ra3] = mem_wd[31:24];
      last_wa  = mem_a;
      last_wd  = mem_wd;
      we_cnt++;
    end
  end

  always @(posedge clk) if (rst_n && req_valid && req_ready) acc_cnt++;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 'x; er = 1'bx;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctrl got %b exp 1000", {req_ready, rsp_valid, rsp_err, mem_we});
    end
    cmp++;
    if ({mem_a, mem_wd, rsp_rdata} !== 96'd0) begin
      bad++; $display("FAIL reset_data got a=%h wd=%h rd=%h exp 0", mem_a, mem_wd, rsp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw_load;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = we_cnt;
    issue(1'b1, 3'd2, 32'h0001_0000, 32'hDEAD_BEEF, lat, rd, er);
    cmp++;
    if (lat !== 2 || er !== 1'b0 || we_cnt - w0 !== 1) begin
      bad++; $display("FAIL sw got lat=%0d err=%b writes=%0d exp 2 0 1", lat, er, we_cnt - w0);
    end
    issue(1'b0, 3'd2, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'hDEAD_BEEF || lat !== 2 || er !== 1'b0) begin
      bad++; $display("FAIL lw got %h lat=%0d exp deadbeef lat=2", rd, lat);
    end
    issue(1'b0, 3'd0, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'hFFFF_FFEF) begin bad++; $display("FAIL lb got %h exp ffffffef", rd); end
    issue(1'b0, 3'd4, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'h0000_00EF) begin bad++; $display("FAIL lbu got %h exp 000000ef", rd); end
    issue(1'b0, 3'd5, 32'h0001_0002, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'h0000_DEAD) begin bad++; $display("FAIL lhu got %h exp 0000dead", rd); end
    issue(1'b0, 3'd1, 32'h0001_0002, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'hFFFF_DEAD) begin bad++; $display("FAIL lh got %h exp ffffdead", rd); end
    cmp++;
    if (we_cnt - w0 !== 1) begin
      bad++; $display("FAIL load_nowrite got writes=%0d exp 1", we_cnt - w0);
    end
  endtask

  task automatic test_sb;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = we_cnt;
    issue(1'b1, 3'd0, 32'h0001_0001, 32'hFFFF_FF12, lat, rd, er);
    cmp++;
    if (lat !== 3 || er !== 1'b0 || we_cnt - w0 !== 1) begin
      bad++; $display("FAIL sb got lat=%0d err=%b writes=%0d exp 3 0 1", lat, er, we_cnt - w0);
    end
    cmp++;
    if (last_wa !== 32'h0001_0001 || last_wd !== 32'h00DE_AD12) begin
      bad++; $display("FAIL sb_word got a=%h d=%h exp 00010001 00dead12", last_wa, last_wd);
    end
    issue(1'b0, 3'd2, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'hDEAD_12EF) begin bad++; $display("FAIL sb_lw got %h exp dead12ef", rd); end
  endtask

  task automatic test_boundary;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = we_cnt;
    issue(1'b1, 3'd1, 32'h0001_FFFE, 32'h0000_A5A5, lat, rd, er);
    cmp++;
    if (lat !== 3 || er !== 1'b0 || we_cnt - w0 !== 1) begin
      bad++; $display("FAIL sh_top got lat=%0d err=%b writes=%0d exp 3 0 1", lat, er, we_cnt - w0);
    end
    issue(1'b0, 3'd5, 32'h0001_FFFE, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'h0000_A5A5 || er !== 1'b0) begin
      bad++; $display("FAIL lhu_top got %h err=%b exp 0000a5a5 0", rd, er);
    end
    issue(1'b0, 3'd0, 32'h0001_FFFF, 32'h0, lat, rd, er);
    cmp++;
    if (rd !== 32'hFFFF_FFA5 || er !== 1'b0) begin
      bad++; $display("FAIL lb_last got %h err=%b exp ffffffa5 0", rd, er);
    end
    w0 = we_cnt;
    issue(1'b1, 3'd2, 32'h0001_FFFE, 32'h1234_5678, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || we_cnt !== w0) begin
      bad++; $display("FAIL sw_over got err=%b lat=%0d rd=%h writes=%0d exp 1 1 0 0", er, lat, rd, we_cnt - w0);
    end
    issue(1'b0, 3'd2, 32'h0002_0000, 32'h0, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL lw_range got err=%b lat=%0d exp 1 1", er, lat);
    end
    issue(1'b0, 3'd4, 32'h8000_0000, 32'h0, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lbu_hi got err=%b rd=%h exp 1 0", er, rd);
    end
  endtask

  task automatic test_funct3;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = we_cnt;
    issue(1'b0, 3'd3, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      bad++; $display("FAIL ld_f3_3 got err=%b rd=%h lat=%0d exp 1 0 1", er, rd, lat);
    end
    issue(1'b0, 3'd6, 32'h0001_0000, 32'h0, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL ld_f3_6 got err=%b rd=%h exp 1 0", er, rd);
    end
    issue(1'b1, 3'd4, 32'h0001_0000, 32'hCAFE_F00D, lat, rd, er);
    cmp++;
    if (er !== 1'b1 || rd !== 32'h0 || we_cnt !== w0) begin
      bad++; $display("FAIL st_f3_4 got err=%b rd=%h writes=%0d exp 1 0 0", er, rd, we_cnt - w0);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd0; addr = 32'h0000_0200; wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp++;
    if (we_cnt !== w0 || ram[17'h200] !== 8'h00) begin
      bad++; $display("FAIL rst_mid_write got writes=%0d byte=%h exp 0 00", we_cnt - w0, ram[17'h200]);
    end
    cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000 || {mem_a, mem_wd, rsp_rdata} !== 96'd0) begin
      bad++; $display("FAIL rst_mid_out got rdy=%b v=%b e=%b we=%b a=%h wd=%h exp 1 0 0 0 0 0",
                      req_ready, rsp_valid, rsp_err, mem_we, mem_a, mem_wd);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp++;
    if (we_cnt !== w0) begin bad++; $display("FAIL rst_mid_after got writes=%0d exp 0", we_cnt - w0); end
  endtask

  task automatic test_back_to_back;
    int lat; int a0; int w0;
    a0 = acc_cnt; w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h0000_0100; wdata = 32'h1111_1111;
    @(posedge clk);
    #1 req_we = 1'b0; wdata = 32'h0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    cmp++;
    if (lat !== 2 || req_ready !== 1'b0 || acc_cnt - a0 !== 1) begin
      bad++; $display("FAIL b2b_first got lat=%0d rdy=%b acc=%0d exp 2 0 1", lat, req_ready, acc_cnt - a0);
    end
    @(negedge clk);
    cmp++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    cmp++;
    if (lat !== 2 || rsp_rdata !== 32'h1111_1111 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL b2b_second got lat=%0d rd=%h exp 2 11111111", lat, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    cmp++;
    if (acc_cnt - a0 !== 2 || we_cnt - w0 !== 1) begin
      bad++; $display("FAIL b2b_count got acc=%0d writes=%0d exp 2 1", acc_cnt - a0, we_cnt - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_sw_load();
    test_sb();
    test_boundary();
    test_funct3();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
